// File: rtl/alu_op_sequencer_if.sv
// Command and result streams of alu_op_sequencer. The sequencer uses the slave
// modport; the command source / result consumer uses the master modport.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
);
    // Both streams: a beat transfers on a rising clock edge where valid && ready;
    // once valid is high the payload holds steady and valid stays high until that edge.
    logic                 cmd_valid_in;
    logic                 cmd_ready_out;
    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     b_in;
    logic [SEL_W-1:0]     op_start_in;
    logic [SEL_W-1:0]     op_count_in;

    logic                 res_valid_out;
    logic                 res_ready_in;
    logic [2*WIDTH-1:0]   res_data_out;
    logic [SEL_W-1:0]     res_sel_out;
    logic                 res_gt_out;
    logic                 res_eq_out;
    logic                 res_last_out;

    modport slave (
        input  cmd_valid_in, a_in, b_in, op_start_in, op_count_in, res_ready_in,
        output cmd_ready_out, res_valid_out, res_data_out, res_sel_out,
               res_gt_out, res_eq_out, res_last_out
    );

    modport master (
        output cmd_valid_in, a_in, b_in, op_start_in, op_count_in, res_ready_in,
        input  cmd_ready_out, res_valid_out, res_data_out, res_sel_out,
               res_gt_out, res_eq_out, res_last_out
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sweeps a range of ALU ops over one operand pair and streams each result out.
// Optional ALU_SEQ_ABORT_EN adds abort_in, which cancels a running sweep.
module alu_op_sequencer #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    alu_op_sequencer_if.slave   bus,
    output logic [WIDTH-1:0]    d0_out,
    output logic [WIDTH-1:0]    d1_out,
    output logic [SEL_W-1:0]    sel_out,
    input  logic [2*WIDTH-1:0]  alu_res_in,
    input  logic                alu_gt_in,
    input  logic                alu_eq_in,
    output logic                busy_out,
    output logic [1:0]          dbg_state_out
`ifdef ALU_SEQ_ABORT_EN
    ,
    input  logic                abort_in
`endif
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_HOLD = 2'd2} state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [WIDTH-1:0]     r_d0;
    logic [WIDTH-1:0]     r_d1;
    logic [SEL_W-1:0]     r_sel;
    logic [SEL_W:0]       r_remaining;
    logic                 r_res_valid;
    logic [2*WIDTH-1:0]   r_res_data;
    logic [SEL_W-1:0]     r_res_sel;
    logic                 r_res_gt;
    logic                 r_res_eq;
    logic                 r_res_last;
    logic                 w_abort;
    logic [SEL_W:0]       w_count_init;

`ifdef ALU_SEQ_ABORT_EN
    assign w_abort = abort_in;
`else
    assign w_abort = 1'b0;
`endif

    // A count of zero encodes the full op space.
    assign w_count_init = (bus.op_count_in == '0) ? (SEL_W+1)'(1 << SEL_W)
                                                  : {1'b0, bus.op_count_in};

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.cmd_valid_in) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = w_abort ? S_IDLE : S_HOLD;
            S_HOLD: begin
                if (w_abort)
                    w_next_state = S_IDLE;
                else if (bus.res_ready_in)
                    w_next_state = r_res_last ? S_IDLE : S_ISSUE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= S_IDLE;
            r_d0        <= '0;
            r_d1        <= '0;
            r_sel       <= '0;
            r_remaining <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_sel   <= '0;
            r_res_gt    <= 1'b0;
            r_res_eq    <= 1'b0;
            r_res_last  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid_in) begin
                        r_d0        <= bus.a_in;
                        r_d1        <= bus.b_in;
                        r_sel       <= bus.op_start_in;
                        r_remaining <= w_count_init;
                    end
                end
                S_ISSUE: begin
                    // ALU inputs have been stable a full cycle, so its outputs are settled here.
                    if (!w_abort) begin
                        r_res_data  <= alu_res_in;
                        r_res_gt    <= alu_gt_in;
                        r_res_eq    <= alu_eq_in;
                        r_res_sel   <= r_sel;
                        r_res_last  <= (r_remaining == (SEL_W+1)'(1));
                        r_res_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_abort) begin
                        r_res_valid <= 1'b0;
                    end else if (bus.res_ready_in) begin
                        r_res_valid <= 1'b0;
                        if (!r_res_last) begin
                            r_sel       <= r_sel + SEL_W'(1);
                            r_remaining <= r_remaining - (SEL_W+1)'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready_out = (r_state == S_IDLE);
    assign bus.res_valid_out = r_res_valid;
    assign bus.res_data_out  = r_res_data;
    assign bus.res_sel_out   = r_res_sel;
    assign bus.res_gt_out    = r_res_gt;
    assign bus.res_eq_out    = r_res_eq;
    assign bus.res_last_out  = r_res_last;
    assign d0_out            = r_d0;
    assign d1_out            = r_d1;
    assign sel_out           = r_sel;
    assign busy_out          = (r_state != S_IDLE);
    assign dbg_state_out     = r_state;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural ALU between d*/sel_out and alu_*_in.
// Build with +define+ALU_SEQ_ABORT_EN to also cover abort_in.
module tb_alu_op_sequencer;
    localparam int WIDTH = 8;
    localparam int SEL_W = 3;
    localparam int DW    = 2 * WIDTH;
    localparam int EW    = DW + SEL_W + 3;

    logic clk_in = 1'b0;
    logic rst_n_in;
    always #5 clk_in = ~clk_in;

    alu_op_sequencer_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();
    logic [WIDTH-1:0] d0_out;
    logic [WIDTH-1:0] d1_out;
    logic [SEL_W-1:0] sel_out;
    logic [DW-1:0]    alu_res_in;
    logic             alu_gt_in;
    logic             alu_eq_in;
    logic             busy_out;
    logic [1:0]       dbg_state_out;
`ifdef ALU_SEQ_ABORT_EN
    logic             abort_in = 1'b0;
`endif

    alu_op_sequencer #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .bus           (bus.slave),
        .d0_out        (d0_out),
        .d1_out        (d1_out),
        .sel_out       (sel_out),
        .alu_res_in    (alu_res_in),
        .alu_gt_in     (alu_gt_in),
        .alu_eq_in     (alu_eq_in),
        .busy_out      (busy_out),
        .dbg_state_out (dbg_state_out)
`ifdef ALU_SEQ_ABORT_EN
        ,
        .abort_in      (abort_in)
`endif
    );

    // Returns {eq, gt, res}.
    function automatic logic [DW+1:0] alu_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [SEL_W-1:0] s);
        logic [DW-1:0] r;
        case (s)
            3'd0:    r = DW'(a) + DW'(b);
            3'd1:    r = DW'(a) - DW'(b);
            3'd2:    r = DW'(a) * DW'(b);
            3'd3:    r = DW'(a & b);
            3'd4:    r = DW'(a | b);
            3'd5:    r = DW'(a ^ b);
            3'd6:    r = DW'(a) << b[2:0];
            default: r = {b, a};
        endcase
        return {(a == b), (a > b), r};
    endfunction

    assign {alu_eq_in, alu_gt_in, alu_res_in} = alu_model(d0_out, d1_out, sel_out);

    // Scoreboard entries are {last, eq, gt, sel, data}.
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_act;
    logic [EW-1:0] mon_exp;
    int n_checks = 0;
    int n_pass   = 0;

    always @(negedge clk_in) begin
        if (rst_n_in && bus.res_valid_out && bus.res_ready_in) begin
            mon_act = {bus.res_last_out, bus.res_eq_out, bus.res_gt_out, bus.res_sel_out, bus.res_data_out};
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL result_unexpected got=%h expected=none", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp)
                    $display("FAIL result_stream got=%h expected=%h", mon_act, mon_exp);
                else
                    n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_cmd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [SEL_W-1:0] st, input logic [SEL_W-1:0] cnt);
        int n;
        int t;
        logic [SEL_W-1:0] s;
        logic [DW+1:0] m;
        n = (cnt == '0) ? (1 << SEL_W) : int'(cnt);
        bus.a_in = a;
        bus.b_in = b;
        bus.op_start_in = st;
        bus.op_count_in = cnt;
        bus.cmd_valid_in = 1'b1;
        t = 0;
        while (!bus.cmd_ready_out && t < 50) begin
            tick();
            t++;
        end
        if (!bus.cmd_ready_out) begin
            n_checks++;
            $display("FAIL cmd_accept_timeout got=cmd_ready_out 0 expected=1");
        end else begin
            for (int k = 0; k < n; k++) begin
                s = st + SEL_W'(k);
                m = alu_model(a, b, s);
                exp_q.push_back({(k == n - 1), m[DW+1], m[DW], s, m[DW-1:0]});
            end
        end
        tick();
        bus.cmd_valid_in = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        @(negedge clk_in);
        while (busy_out && t < budget) begin
            @(negedge clk_in);
            t++;
        end
        n_checks++;
        if (busy_out) $display("FAIL idle_timeout got=busy 1 expected=0");
        else n_pass++;
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL %s_drained got=%0d pending expected=0", name, exp_q.size());
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        bus.cmd_valid_in = 1'b0;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.op_start_in = '0;
        bus.op_count_in = '0;
        bus.res_ready_in = 1'b0;
        #12;
        n_checks++;
        if ({bus.cmd_ready_out, busy_out, bus.res_valid_out, sel_out, d0_out, bus.res_data_out} !==
            {1'b1, 1'b0, 1'b0, {SEL_W{1'b0}}, {WIDTH{1'b0}}, {DW{1'b0}}})
            $display("FAIL reset_state got=rdy%b busy%b val%b sel%0d d0%0d res%0d expected=rdy1 busy0 val0 sel0 d00 res0",
                     bus.cmd_ready_out, busy_out, bus.res_valid_out, sel_out, d0_out, bus.res_data_out);
        else n_pass++;
        tick();
        rst_n_in = 1'b1;
        tick();
    endtask

    task automatic test_full_sweep();
        bus.res_ready_in = 1'b1;
        send_cmd(8'd12, 8'd45, 3'd0, 3'd0);
        @(negedge clk_in);
        n_checks++;
        if ({bus.res_valid_out, busy_out} !== 2'b01)
            $display("FAIL latency_issue got=val%b busy%b expected=val0 busy1", bus.res_valid_out, busy_out);
        else n_pass++;
        tick();
        @(negedge clk_in);
        n_checks++;
        if (bus.res_valid_out !== 1'b1 || bus.res_sel_out !== 3'd0)
            $display("FAIL latency_first got=val%b sel%0d expected=val1 sel0", bus.res_valid_out, bus.res_sel_out);
        else n_pass++;
        wait_idle(40);
        check_drained("full_sweep");
    endtask

    task automatic test_wrap();
        int t;
        bus.res_ready_in = 1'b1;
        send_cmd(8'd200, 8'd200, 3'd6, 3'd3);
        t = 0;
        @(negedge clk_in);
        while (!(bus.res_valid_out && bus.res_last_out) && t < 20) begin
            @(negedge clk_in);
            t++;
        end
        @(negedge clk_in);
        n_checks++;
        if ({busy_out, bus.cmd_ready_out} !== 2'b01)
            $display("FAIL wrap_idle_after_last got=busy%b rdy%b expected=busy0 rdy1", busy_out, bus.cmd_ready_out);
        else n_pass++;
        check_drained("wrap");
    endtask

    task automatic test_backpressure();
        int t;
        logic [EW-1:0] snap;
        bus.res_ready_in = 1'b0;
        send_cmd(8'd7, 8'd3, 3'd0, 3'd4);
        for (int r = 0; r < 4; r++) begin
            t = 0;
            @(negedge clk_in);
            while (!bus.res_valid_out && t < 10) begin
                @(negedge clk_in);
                t++;
            end
            if (bus.res_valid_out && bus.res_sel_out == 3'd2) begin
                snap = {bus.res_last_out, bus.res_eq_out, bus.res_gt_out, bus.res_sel_out, bus.res_data_out};
                for (int c = 0; c < 5; c++) begin
                    tick();
                    @(negedge clk_in);
                    n_checks++;
                    if (bus.res_valid_out !== 1'b1 || sel_out !== 3'd2 ||
                        {bus.res_last_out, bus.res_eq_out, bus.res_gt_out, bus.res_sel_out, bus.res_data_out} !== snap)
                        $display("FAIL backpressure_hold cyc%0d got=val%b sel_out%0d res=%h expected=val1 sel_out2 res=%h",
                                 c, bus.res_valid_out, sel_out,
                                 {bus.res_last_out, bus.res_eq_out, bus.res_gt_out, bus.res_sel_out, bus.res_data_out}, snap);
                    else n_pass++;
                end
            end
            tick();
            bus.res_ready_in = 1'b1;
            tick();
            bus.res_ready_in = 1'b0;
        end
        bus.res_ready_in = 1'b1;
        wait_idle(20);
        check_drained("backpressure");
    endtask

    task automatic test_busy_reject();
        bus.res_ready_in = 1'b1;
        send_cmd(8'd10, 8'd20, 3'd0, 3'd0);
        tick();
        tick();
        bus.a_in = 8'd1;
        bus.cmd_valid_in = 1'b1;
        @(negedge clk_in);
        n_checks++;
        if (bus.cmd_ready_out !== 1'b0)
            $display("FAIL busy_ready got=%b expected=0", bus.cmd_ready_out);
        else n_pass++;
        tick();
        bus.cmd_valid_in = 1'b0;
        @(negedge clk_in);
        n_checks++;
        if (d0_out !== 8'd10) $display("FAIL busy_d0_kept got=%0d expected=10", d0_out);
        else n_pass++;
        wait_idle(40);
        check_drained("busy_reject");
        send_cmd(8'd5, 8'd6, 3'd3, 3'd2);
        wait_idle(20);
        check_drained("after_reject");
    endtask

    task automatic test_reset_mid();
        int t;
        bus.res_ready_in = 1'b0;
        send_cmd(8'd9, 8'd9, 3'd4, 3'd0);
        t = 0;
        @(negedge clk_in);
        while (!bus.res_valid_out && t < 10) begin
            @(negedge clk_in);
            t++;
        end
        n_checks++;
        if (bus.res_valid_out !== 1'b1 || sel_out !== 3'd4)
            $display("FAIL reset_mid_pre got=val%b sel_out%0d expected=val1 sel_out4", bus.res_valid_out, sel_out);
        else n_pass++;
        #2;
        rst_n_in = 1'b0;
        #1;
        n_checks++;
        if ({bus.res_valid_out, busy_out, sel_out, bus.cmd_ready_out} !== {1'b0, 1'b0, 3'd0, 1'b1})
            $display("FAIL reset_mid_state got=val%b busy%b sel_out%0d rdy%b expected=val0 busy0 sel_out0 rdy1",
                     bus.res_valid_out, busy_out, sel_out, bus.cmd_ready_out);
        else n_pass++;
        exp_q.delete();
        tick();
        rst_n_in = 1'b1;
        tick();
        bus.res_ready_in = 1'b1;
        send_cmd(8'd3, 8'd4, 3'd5, 3'd2);
        wait_idle(20);
        check_drained("after_reset");
    endtask

`ifdef ALU_SEQ_ABORT_EN
    task automatic test_abort();
        int t;
        int seen;
        bus.res_ready_in = 1'b1;
        send_cmd(8'd50, 8'd25, 3'd0, 3'd0);
        t = 0;
        @(negedge clk_in);
        while (!(bus.res_valid_out && bus.res_sel_out == 3'd3) && t < 20) begin
            @(negedge clk_in);
            t++;
        end
        abort_in = 1'b1;
        @(posedge clk_in);
        #1;
        abort_in = 1'b0;
        @(negedge clk_in);
        n_checks++;
        if ({busy_out, bus.cmd_ready_out, bus.res_valid_out} !== 3'b010)
            $display("FAIL abort_idle got=busy%b rdy%b val%b expected=busy0 rdy1 val0",
                     busy_out, bus.cmd_ready_out, bus.res_valid_out);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 4) $display("FAIL abort_delivered got=%0d pending expected=4", exp_q.size());
        else n_pass++;
        exp_q.delete();
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_in);
            if (bus.res_valid_out) seen++;
        end
        n_checks++;
        if (seen != 0) $display("FAIL abort_no_more got=%0d valid cycles expected=0", seen);
        else n_pass++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_full_sweep();
        test_wrap();
        test_backpressure();
        test_busy_reject();
        test_reset_mid();
`ifdef ALU_SEQ_ABORT_EN
        test_abort();
`endif
        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
